// File: rtl/px_stream_pkg.sv
// Shared constants and types for the pixel stream router slice.
package px_stream_pkg;

  localparam int MAX_PIXEL_BITS = 8;
  localparam int PX_W_DEF       = MAX_PIXEL_BITS;

  localparam int SRC_SPI     = 0;
  localparam int SRC_LFSR    = 1;
  localparam int NUM_SRC_DEF = SRC_LFSR + 1;

  typedef enum logic {
    ACTIVE = 1'b0,
    DRAIN  = 1'b1
  } route_state_t;

endpackage

// File: rtl/px_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy output and a drop strobe.
module px_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [LVL_W-1:0] level_o,
  output logic             drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full    = (level_o == LVL_W'(DEPTH));
  assign valid_o = (level_o != '0);
  assign do_pop  = pop_i && valid_o && !clear_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && !clear_i && (!full || do_pop);
  assign drop_o  = push_i && !clear_i && full && !do_pop;
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_o <= level_o + LVL_W'(1);
        2'b01:   level_o <= level_o - LVL_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/px_stream_router.sv
// Steers one of NUM_SRC pixel sources into the core, tracks pixels in flight and
// buffers core results; source switches wait until the pipeline has drained.
module px_stream_router
  import px_stream_pkg::*;
#(
  parameter int PX_W         = PX_W_DEF,
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int SEL_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int LVL_W        = $clog2(FIFO_DEPTH + 1),
  parameter int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                    clk_i,
  input  logic                    nreset_i,
  input  logic [SEL_W-1:0]        mode_req_i,
  output logic [SEL_W-1:0]        mode_o,
  output logic                    switch_pending_o,
  input  logic [NUM_SRC*PX_W-1:0] src_px_i,
  input  logic [NUM_SRC-1:0]      src_rdy_i,
  output logic [PX_W-1:0]         core_px_o,
  output logic                    core_rdy_o,
  input  logic [PX_W-1:0]         core_px_i,
  input  logic                    core_rdy_i,
  output logic [PX_W-1:0]         out_px_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LVL_W-1:0]        fifo_level_o,
  output logic [INF_W-1:0]        inflight_o,
  output logic                    overflow_o,
  input  logic                    clear_i,
  output route_state_t            state_o
);

  // Output handshake: the head word in out_px_o transfers on any clock edge where
  // out_valid_o and out_ready_i are both high; out_valid_o never drops without a transfer
  // except on clear_i or reset.

  logic [31:0]      req_wide;
  logic [SEL_W-1:0] req_eff;
  logic [PX_W-1:0]  sel_px;
  logic             sel_rdy;
  logic             accept;
  logic             inflight_full;
  logic             issue;
  logic             ret;
  logic             fifo_drop;
  logic             drained;

  assign req_wide = 32'(mode_req_i);
  assign req_eff  = (req_wide >= 32'(NUM_SRC)) ? SEL_W'(SRC_SPI) : mode_req_i;

  always_comb begin
    sel_px  = '0;
    sel_rdy = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (mode_o == SEL_W'(k)) begin
        sel_px  = src_px_i[k*PX_W +: PX_W];
        sel_rdy = src_rdy_i[k];
      end
    end
  end

  assign accept        = (state_o == ACTIVE) && sel_rdy && !clear_i;
  assign inflight_full = (inflight_o == INF_W'(MAX_INFLIGHT));
  assign issue         = accept && !inflight_full;
  assign ret           = core_rdy_i && !clear_i;
  assign drained       = (inflight_o == '0) && !out_valid_o;

  px_sync_fifo #(
    .WIDTH (PX_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .clear_i  (clear_i),
    .push_i   (core_rdy_i),
    .data_i   (core_px_i),
    .pop_i    (out_ready_i),
    .data_o   (out_px_o),
    .valid_o  (out_valid_o),
    .level_o  (fifo_level_o),
    .drop_o   (fifo_drop)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_o          <= ACTIVE;
      mode_o           <= SEL_W'(SRC_SPI);
      switch_pending_o <= 1'b0;
      core_rdy_o       <= 1'b0;
      core_px_o        <= '0;
      inflight_o       <= '0;
      overflow_o       <= 1'b0;
    end else begin
      core_rdy_o <= issue;
      if (issue) core_px_o <= sel_px;

      if (clear_i) begin
        inflight_o <= '0;
        overflow_o <= 1'b0;
      end else begin
        // Simultaneous issue and return cancel; a stray return saturates at zero.
        case ({issue, ret})
          2'b10:   inflight_o <= inflight_o + INF_W'(1);
          2'b01:   if (inflight_o != '0) inflight_o <= inflight_o - INF_W'(1);
          default: ;
        endcase
        if ((accept && inflight_full) || fifo_drop) overflow_o <= 1'b1;
      end

      case (state_o)
        ACTIVE: begin
          if (req_eff != mode_o) begin
            state_o          <= DRAIN;
            switch_pending_o <= 1'b1;
          end
        end
        DRAIN: begin
          if (req_eff == mode_o) begin
            state_o          <= ACTIVE;
            switch_pending_o <= 1'b0;
          end else if (drained) begin
            state_o          <= ACTIVE;
            mode_o           <= req_eff;
            switch_pending_o <= 1'b0;
          end
        end
        default: begin
          state_o          <= ACTIVE;
          switch_pending_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_px_stream_router.sv
// Bench for px_stream_router: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_px_stream_router;
  import px_stream_pkg::*;

  localparam int PX_W         = 8;
  localparam int NUM_SRC      = 2;
  localparam int SEL_W        = 1;
  localparam int FIFO_DEPTH   = 4;
  localparam int MAX_INFLIGHT = 8;
  localparam int LVL_W        = 3;
  localparam int INF_W        = 4;

  logic                    clk_i = 1'b0;
  logic                    nreset_i = 1'b0;
  logic [SEL_W-1:0]        mode_req_i = '0;
  logic [SEL_W-1:0]        mode_o;
  logic                    switch_pending_o;
  logic [NUM_SRC*PX_W-1:0] src_px_i;
  logic [NUM_SRC-1:0]      src_rdy_i = '0;
  logic [PX_W-1:0]         core_px_o;
  logic                    core_rdy_o;
  logic [PX_W-1:0]         core_px_i = '0;
  logic                    core_rdy_i = 1'b0;
  logic [PX_W-1:0]         out_px_o;
  logic                    out_valid_o;
  logic                    out_ready_i = 1'b0;
  logic [LVL_W-1:0]        fifo_level_o;
  logic [INF_W-1:0]        inflight_o;
  logic                    overflow_o;
  logic                    clear_i = 1'b0;
  route_state_t            state_o;

  logic [PX_W-1:0] px0 = '0;
  logic [PX_W-1:0] px1 = '0;
  assign src_px_i = {px1, px0};

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  px_stream_router #(
    .PX_W(PX_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_INFLIGHT(MAX_INFLIGHT), .LVL_W(LVL_W), .INF_W(INF_W)
  ) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .mode_req_i(mode_req_i), .mode_o(mode_o),
    .switch_pending_o(switch_pending_o), .src_px_i(src_px_i), .src_rdy_i(src_rdy_i),
    .core_px_o(core_px_o), .core_rdy_o(core_rdy_o), .core_px_i(core_px_i),
    .core_rdy_i(core_rdy_i), .out_px_o(out_px_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .fifo_level_o(fifo_level_o), .inflight_o(inflight_o),
    .overflow_o(overflow_o), .clear_i(clear_i), .state_o(state_o)
  );

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] rdy, input logic [7:0] p0, input logic [7:0] p1,
                       input logic crdy, input logic [7:0] cpx, input logic ordy,
                       input logic clr);
    src_rdy_i   = rdy;
    px0         = p0;
    px1         = p1;
    core_rdy_i  = crdy;
    core_px_i   = cpx;
    out_ready_i = ordy;
    clear_i     = clr;
  endtask

  task automatic idle();
    drive(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // vector table
  typedef struct {
    logic [1:0] rdy;
    logic [7:0] px0;
    logic [7:0] px1;
    logic       crdy;
    logic [7:0] cpx;
    logic       ordy;
    logic       clr;
    logic       e_crdy;
    logic [7:0] e_cpx;
    logic [3:0] e_inf;
    logic [2:0] e_lvl;
    logic       e_val;
    logic [7:0] e_opx;
    logic       e_ovf;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic [1:0] rdy, logic [7:0] p0, logic [7:0] p1, logic crdy,
                              logic [7:0] cpx, logic ordy, logic clr, logic e_crdy,
                              logic [7:0] e_cpx, logic [3:0] e_inf, logic [2:0] e_lvl,
                              logic e_val, logic [7:0] e_opx, logic e_ovf);
    vec_t v;
    v.rdy = rdy; v.px0 = p0; v.px1 = p1; v.crdy = crdy; v.cpx = cpx; v.ordy = ordy;
    v.clr = clr; v.e_crdy = e_crdy; v.e_cpx = e_cpx; v.e_inf = e_inf; v.e_lvl = e_lvl;
    v.e_val = e_val; v.e_opx = e_opx; v.e_ovf = e_ovf;
    return v;
  endfunction

  // scoreboard / reference model state
  logic [PX_W-1:0] exp_q[$];
  int              m_inf;
  int              m_mode;
  bit              m_pend;
  bit              m_ovf;
  bit              m_crdy;
  logic [PX_W-1:0] m_cpx;

  task automatic model_cycle(input logic [1:0] rdy, input logic [7:0] p0, input logic [7:0] p1,
                             input logic crdy, input logic [7:0] cpx, input logic ordy,
                             input logic clr, input int req);
    int  old_inf;
    int  old_sz;
    bit  was_pend;
    int  cur_mode;
    bit  acc;
    bit  iss;
    bit  pop;
    old_inf  = m_inf;
    old_sz   = exp_q.size();
    was_pend = m_pend;
    cur_mode = m_mode;
    m_crdy   = 1'b0;
    if (clr) begin
      exp_q.delete();
      m_inf = 0;
      m_ovf = 1'b0;
    end else begin
      acc = !was_pend && rdy[cur_mode];
      iss = acc && (m_inf < MAX_INFLIGHT);
      pop = ordy && (exp_q.size() > 0);
      if (acc && !iss) m_ovf = 1'b1;
      if (iss) begin
        m_crdy = 1'b1;
        m_cpx  = (cur_mode == 1) ? p1 : p0;
      end
      if (crdy && exp_q.size() == FIFO_DEPTH && !pop) m_ovf = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (crdy && exp_q.size() < FIFO_DEPTH) exp_q.push_back(cpx);
      if (iss && !crdy) m_inf++;
      else if (!iss && crdy && m_inf > 0) m_inf--;
    end
    if (was_pend) begin
      if (req == cur_mode) m_pend = 1'b0;
      else if (old_inf == 0 && old_sz == 0) begin
        m_mode = req;
        m_pend = 1'b0;
      end
    end else if (req != cur_mode) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic compare_model();
    check("rnd core_rdy", 32'(core_rdy_o), 32'(m_crdy));
    check("rnd core_px", 32'(core_px_o), 32'(m_cpx));
    check("rnd inflight", 32'(inflight_o), 32'(m_inf));
    check("rnd level", 32'(fifo_level_o), 32'(exp_q.size()));
    check("rnd out_valid", 32'(out_valid_o), 32'(exp_q.size() > 0));
    check("rnd out_px", 32'(out_px_o), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
    check("rnd overflow", 32'(overflow_o), 32'(m_ovf));
    check("rnd mode", 32'(mode_o), 32'(m_mode));
    check("rnd pending", 32'(switch_pending_o), 32'(m_pend));
  endtask

  task automatic do_reset();
    idle();
    mode_req_i = '0;
    nreset_i   = 1'b0;
    repeat (2) step();
    nreset_i = 1'b1;
    step();
  endtask

  int pulses;
  int empty_cyc;
  int switched_cyc;
  logic [7:0] drain_data[3];

  initial begin
    vecs[0]  = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(2'b01, 8'h5A, 8'h00, 0, 8'h00, 0, 0,  1, 8'h5A, 1, 0, 0, 8'h00, 0);
    vecs[2]  = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 0, 0,  0, 8'h5A, 1, 0, 0, 8'h00, 0);
    vecs[3]  = mk(2'b00, 8'h00, 8'h00, 1, 8'hA5, 0, 0,  0, 8'h5A, 0, 1, 1, 8'hA5, 0);
    vecs[4]  = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 1, 0,  0, 8'h5A, 0, 0, 0, 8'h00, 0);
    vecs[5]  = mk(2'b10, 8'h00, 8'h33, 0, 8'h00, 0, 0,  0, 8'h5A, 0, 0, 0, 8'h00, 0);
    vecs[6]  = mk(2'b00, 8'h00, 8'h00, 1, 8'h01, 0, 0,  0, 8'h5A, 0, 1, 1, 8'h01, 0);
    vecs[7]  = mk(2'b00, 8'h00, 8'h00, 1, 8'h02, 0, 0,  0, 8'h5A, 0, 2, 1, 8'h01, 0);
    vecs[8]  = mk(2'b00, 8'h00, 8'h00, 1, 8'h03, 0, 0,  0, 8'h5A, 0, 3, 1, 8'h01, 0);
    vecs[9]  = mk(2'b00, 8'h00, 8'h00, 1, 8'h04, 0, 0,  0, 8'h5A, 0, 4, 1, 8'h01, 0);
    vecs[10] = mk(2'b00, 8'h00, 8'h00, 1, 8'h05, 0, 0,  0, 8'h5A, 0, 4, 1, 8'h01, 1);
    vecs[11] = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 1, 0,  0, 8'h5A, 0, 3, 1, 8'h02, 1);
    vecs[12] = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 1, 0,  0, 8'h5A, 0, 2, 1, 8'h03, 1);
    vecs[13] = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 1, 0,  0, 8'h5A, 0, 1, 1, 8'h04, 1);
    vecs[14] = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 1, 0,  0, 8'h5A, 0, 0, 0, 8'h00, 1);
    vecs[15] = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 0, 1,  0, 8'h5A, 0, 0, 0, 8'h00, 0);
    vecs[16] = mk(2'b00, 8'h00, 8'h00, 1, 8'h11, 0, 0,  0, 8'h5A, 0, 1, 1, 8'h11, 0);
    vecs[17] = mk(2'b00, 8'h00, 8'h00, 1, 8'h12, 0, 0,  0, 8'h5A, 0, 2, 1, 8'h11, 0);
    vecs[18] = mk(2'b00, 8'h00, 8'h00, 1, 8'h13, 0, 0,  0, 8'h5A, 0, 3, 1, 8'h11, 0);
    vecs[19] = mk(2'b00, 8'h00, 8'h00, 1, 8'h14, 0, 0,  0, 8'h5A, 0, 4, 1, 8'h11, 0);
    vecs[20] = mk(2'b00, 8'h00, 8'h00, 1, 8'h15, 1, 0,  0, 8'h5A, 0, 4, 1, 8'h12, 0);
    vecs[21] = mk(2'b01, 8'h99, 8'h00, 1, 8'h16, 1, 1,  0, 8'h5A, 0, 0, 0, 8'h00, 0);
    vecs[22] = mk(2'b00, 8'h00, 8'h00, 0, 8'h00, 0, 0,  0, 8'h5A, 0, 0, 0, 8'h00, 0);

    // reset state
    do_reset();
    check("reset mode", 32'(mode_o), 32'h0);
    check("reset pending", 32'(switch_pending_o), 32'h0);
    check("reset core_rdy", 32'(core_rdy_o), 32'h0);
    check("reset out_valid", 32'(out_valid_o), 32'h0);
    check("reset level", 32'(fifo_level_o), 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rdy, vecs[i].px0, vecs[i].px1, vecs[i].crdy, vecs[i].cpx,
            vecs[i].ordy, vecs[i].clr);
      step();
      check($sformatf("vec%0d core_rdy", i), 32'(core_rdy_o), 32'(vecs[i].e_crdy));
      check($sformatf("vec%0d core_px", i), 32'(core_px_o), 32'(vecs[i].e_cpx));
      check($sformatf("vec%0d inflight", i), 32'(inflight_o), 32'(vecs[i].e_inf));
      check($sformatf("vec%0d level", i), 32'(fifo_level_o), 32'(vecs[i].e_lvl));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid_o), 32'(vecs[i].e_val));
      check($sformatf("vec%0d out_px", i), 32'(out_px_o), 32'(vecs[i].e_opx));
      check($sformatf("vec%0d overflow", i), 32'(overflow_o), 32'(vecs[i].e_ovf));
    end

    // mode drain: inflight 2, level 1, then request source 1
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 8'(8'h21 + i), 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      step();
    end
    drive(2'b00, 8'h00, 8'h00, 1'b1, 8'hC1, 1'b0, 1'b0);
    step();
    check("drain pre inflight", 32'(inflight_o), 32'd2);
    check("drain pre level", 32'(fifo_level_o), 32'd1);
    idle();
    mode_req_i = 1'b1;
    step();
    check("drain pending", 32'(switch_pending_o), 32'h1);
    check("drain state", 32'(state_o), 32'(DRAIN));
    check("drain mode held", 32'(mode_o), 32'h0);
    drive(2'b11, 8'h44, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("drain src ignored", 32'(core_rdy_o), 32'h0);
    check("drain inflight held", 32'(inflight_o), 32'd2);
    drive(2'b00, 8'h00, 8'h00, 1'b1, 8'hC2, 1'b0, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0);
    step();
    check("drain level3", 32'(fifo_level_o), 32'd3);
    check("drain inflight0", 32'(inflight_o), 32'd0);
    check("drain still pending", 32'(switch_pending_o), 32'h1);
    drain_data[0] = 8'hC1; drain_data[1] = 8'hC2; drain_data[2] = 8'hC3;
    empty_cyc = -1;
    switched_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) check($sformatf("drain pop%0d", c), 32'(out_px_o), 32'(drain_data[c]));
      drive(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      step();
      if (fifo_level_o == '0 && empty_cyc < 0) empty_cyc = c;
      if (mode_o == 1'b1 && switched_cyc < 0) switched_cyc = c;
      if (switched_cyc < 0 && empty_cyc < 0)
        check("drain pending while busy", 32'(switch_pending_o), 32'h1);
    end
    check("drain empty cycle", 32'(empty_cyc), 32'd2);
    check("drain switch after empty",
          32'((switched_cyc >= empty_cyc) && (switched_cyc <= empty_cyc + 1)), 32'h1);
    check("drain pending cleared", 32'(switch_pending_o), 32'h0);
    drive(2'b10, 8'h00, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("new src core_rdy", 32'(core_rdy_o), 32'h1);
    check("new src core_px", 32'(core_px_o), 32'h77);
    drive(2'b00, 8'h00, 8'h00, 1'b1, 8'hD1, 1'b1, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    idle();
    mode_req_i = 1'b0;
    step();
    check("cancel pending set", 32'(switch_pending_o), 32'h1);
    mode_req_i = 1'b1;
    step();
    check("cancel pending clr", 32'(switch_pending_o), 32'h0);
    check("cancel mode kept", 32'(mode_o), 32'h1);

    // in-flight limit on source 1
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive(2'b10, 8'h00, 8'(i + 1), 1'b0, 8'h00, 1'b0, 1'b0);
      step();
      if (core_rdy_o) pulses++;
    end
    idle();
    check("limit pulses", 32'(pulses), 32'd8);
    check("limit inflight", 32'(inflight_o), 32'd8);
    check("limit overflow", 32'(overflow_o), 32'h1);
    check("limit core_px", 32'(core_px_o), 32'h08);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 8'h00, 8'h00, 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      step();
    end
    check("pre clear level", 32'(fifo_level_o), 32'd3);
    check("pre clear inflight", 32'(inflight_o), 32'd5);
    drive(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    idle();
    check("clear level", 32'(fifo_level_o), 32'd0);
    check("clear valid", 32'(out_valid_o), 32'h0);
    check("clear inflight", 32'(inflight_o), 32'd0);
    check("clear overflow", 32'(overflow_o), 32'h0);
    check("clear mode", 32'(mode_o), 32'h1);

    // asynchronous reset mid-stream
    drive(2'b10, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 1'b1, 8'h6B, 1'b0, 1'b0);
    step();
    idle();
    #2;
    nreset_i = 1'b0;
    #1;
    check("arst mode", 32'(mode_o), 32'h0);
    check("arst pending", 32'(switch_pending_o), 32'h0);
    check("arst core_px", 32'(core_px_o), 32'h0);
    check("arst out_valid", 32'(out_valid_o), 32'h0);
    check("arst out_px", 32'(out_px_o), 32'h0);
    check("arst level", 32'(fifo_level_o), 32'h0);
    check("arst inflight", 32'(inflight_o), 32'h0);
    mode_req_i = 1'b0;
    #1;
    nreset_i = 1'b1;
    step();

    // randomized run against the reference model
    exp_q.delete();
    m_inf = 0; m_mode = 0; m_pend = 1'b0; m_ovf = 1'b0; m_crdy = 1'b0; m_cpx = '0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] r_rdy;
      logic [7:0] r_p0, r_p1, r_cpx;
      logic       r_crdy, r_ordy, r_clr;
      r_rdy  = 2'($urandom_range(0, 3));
      r_p0   = 8'($urandom);
      r_p1   = 8'($urandom);
      r_crdy = ($urandom_range(0, 2) == 0);
      r_cpx  = 8'($urandom);
      r_ordy = 1'($urandom_range(0, 1));
      r_clr  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) mode_req_i = ~mode_req_i;
      drive(r_rdy, r_p0, r_p1, r_crdy, r_cpx, r_ordy, r_clr);
      model_cycle(r_rdy, r_p0, r_p1, r_crdy, r_cpx, r_ordy, r_clr, int'(mode_req_i));
      step();
      compare_model();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
